pcpi_approx_mul: RTL and testbench

- PCPI responder (co-processor side) for PicoRV32 custom-0 instructions.
- Decodes custom-0 instructions. func7 sets the approximation level; func3 sets the multiply variant.
- Runs an iterative, truncation-based approximate multiply and returns the result on pcpi_rd with pcpi_wr/pcpi_ready.
- Sits beside the core in the PicoSoC, behind the PCPI bus that the core or a bench drives.

---
 rtl/pcpi_approx_mul.sv | 151 +++++++++++++++
 tb/tb_pcpi_approx_mul.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_approx_mul.sv
// PCPI co-processor: truncation-based approximate multiply (custom-0).
// Ports: clk, aresetn, pcpi_valid/insn/rs1/rs2 in; pcpi_wr/rd/wait/ready out.
module pcpi_approx_mul #(
  parameter int BITS_PER_CYCLE = 4,
  parameter int TRUNC_STEP     = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE,
    COOL
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [63:0]   mcand;
  logic [31:0]   mplier;
  logic [63:0]   acc;
  logic [63:0]   pp_sum;
  logic [2:0]    f3_q;
  logic          neg_q;

  logic [1:0]  lvl;
  logic [2:0]  f3;
  logic        match;
  logic        is_mulh;
  logic [31:0] mask;
  logic [31:0] a_t, b_t;
  logic [31:0] a_mag, b_mag;
  logic [63:0] full;
  logic [31:0] res;
  logic        accept;
  logic        unused_bits;

  assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign lvl     = pcpi_insn[26:25];
  assign f3      = pcpi_insn[14:12];
  assign is_mulh = (f3 == 3'd1);

  always_comb begin
    match = 1'b0;
    unique case (1'b1)
      (pcpi_insn[6:0] != 7'b0001011): match = 1'b0;
      (pcpi_insn[31:27] != 5'd0):     match = 1'b0;
      (f3 > 3'd2):                    match = 1'b0;
      default:                        match = 1'b1;
    endcase
  end

  assign accept = (state == IDLE) && pcpi_valid && match;

  // Truncate on the raw pattern, then take magnitudes for MULH only.
  assign mask  = {32{1'b1}} << (int'(lvl) * TRUNC_STEP);
  assign a_t   = pcpi_rs1 & mask;
  assign b_t   = pcpi_rs2 & mask;
  assign a_mag = (is_mulh && a_t[31]) ? (~a_t + 32'd1) : a_t;
  assign b_mag = (is_mulh && b_t[31]) ? (~b_t + 32'd1) : b_t;

  always_comb begin
    pp_sum = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) pp_sum = pp_sum + (mcand << i);
    end
  end

  assign full = neg_q ? (~acc + 64'd1) : acc;

  always_comb begin
    res = full[63:32];
    unique case (1'b1)
      (f3_q == 3'd0): res = full[31:0];
      default:        res = full[63:32];
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (!pcpi_valid)              state_nxt = IDLE;
        else if (cnt == CW'(N - 1))   state_nxt = DONE;
      end
      DONE:    state_nxt = COOL;
      COOL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      mcand  <= {32'd0, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      f3_q   <= f3;
      neg_q  <= is_mulh & (a_t[31] ^ b_t[31]);
    end else if (state == CALC) begin
      cnt    <= cnt + 1'b1;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
      acc    <= pp_sum;
    end
  end

  // Outputs are registered one cycle behind the state; a dropped
  // pcpi_valid clears wait on the same edge that aborts to IDLE.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
    end else begin
      pcpi_wait  <= (state == CALC) && pcpi_valid;
      pcpi_ready <= (state == DONE);
      pcpi_wr    <= (state == DONE);
      if (state == DONE) pcpi_rd <= res;
    end
  end

endmodule

// File: tb/tb_pcpi_approx_mul.sv
// Bench for pcpi_approx_mul: directed ops, scoreboard queue,
// non-claim, abort, reset and back-to-back spacing checks.
module tb_pcpi_approx_mul;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] sb[$];
  logic [31:0] last_exp = '0;

  pcpi_approx_mul dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mk(input int f7, input int f3,
                                     input logic [6:0] op);
    logic [6:0] a;
    logic [2:0] b;
    a = 7'(f7);
    b = 3'(f3);
    return {a, 5'd2, 5'd1, b, 5'd3, op};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] insn,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] mask, at, bt;
    logic [63:0] p;
    mask = 32'hFFFF_FFFF << (4 * int'(insn[26:25]));
    at = a & mask;
    bt = b & mask;
    if (insn[14:12] == 3'd1) begin
      p = $signed({{32{at[31]}}, at}) * $signed({{32{bt[31]}}, bt});
      return p[63:32];
    end
    p = {32'd0, at} * {32'd0, bt};
    if (insn[14:12] == 3'd0) return p[31:0];
    return p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int waits;
    logic [31:0] e;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = insn;
    pcpi_rs1 = a;
    pcpi_rs2 = b;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    chk("wait_at_accept", {31'd0, pcpi_wait}, 32'd0);
    pcpi_rs1 = $urandom;
    pcpi_rs2 = $urandom;
    lat = 0;
    waits = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (pcpi_wait) waits++;
      if (pcpi_ready) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'd9);
    chk("wait_cycles", 32'(waits), 32'd8);
    chk("wr", {31'd0, pcpi_wr}, 32'd1);
    chk("rd", pcpi_rd, e);
    last_exp = e;
    pcpi_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_pulse", {31'd0, pcpi_ready}, 32'd0);
  endtask

  task automatic no_claim(input string tag, input logic [31:0] insn);
    logic seen;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = insn;
    pcpi_rs1 = 32'd3;
    pcpi_rs2 = 32'd4;
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1;
      seen = seen | pcpi_wait | pcpi_ready | pcpi_wr;
    end
    chk(tag, {31'd0, seen}, 32'd0);
    pcpi_valid = 1'b0;
  endtask

  localparam logic [6:0] OP = 7'b0001011;

  initial begin
    logic seen;
    int rc[3];
    logic [31:0] ins, a, b;

    #12;
    chk("reset_outs", {pcpi_wait, pcpi_ready, pcpi_wr, 29'd0}, 32'd0);
    chk("reset_rd", pcpi_rd, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;

    run_op(mk(0, 0, OP), 32'd7, 32'd6, 32'h0000_002A);
    run_op(mk(0, 1, OP), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op(mk(0, 2, OP), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(mk(0, 0, OP), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(mk(0, 1, OP), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op(mk(0, 1, OP), 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op(mk(1, 0, OP), 32'h13, 32'h13, 32'h0000_0100);
    run_op(mk(0, 0, OP), 32'h13, 32'h13, 32'h0000_0169);
    run_op(mk(3, 0, OP), 32'h00A0_0FFF, 32'h00A0_0FFF, 32'h0000_0000);
    run_op(mk(3, 0, OP), 32'h00AB_CDEF, 32'h00AB_CDEF, 32'h1000_0000);
    run_op(mk(2, 1, OP), 32'hFFFF_F123, 32'h0001_2345, 32'hFFFF_FFFF);

    for (int i = 0; i < 6; i++) begin
      ins = mk($urandom_range(0, 3), $urandom_range(0, 2), OP);
      a = $urandom;
      b = $urandom;
      run_op(ins, a, b, model(ins, a, b));
    end

    no_claim("noclaim_opcode", mk(0, 0, 7'b0110011));
    no_claim("noclaim_f7", mk(4, 0, OP));
    no_claim("noclaim_f3", mk(0, 3, OP));

    // abort in CALC cycle 3
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = mk(0, 0, OP);
    pcpi_rs1 = 32'd5;
    pcpi_rs2 = 32'd5;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    pcpi_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wait", {31'd0, pcpi_wait}, 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen = seen | pcpi_ready | pcpi_wr;
    end
    chk("abort_noready", {31'd0, seen}, 32'd0);
    chk("abort_rd_hold", pcpi_rd, last_exp);
    run_op(mk(0, 0, OP), 32'd9, 32'd11, 32'd99);

    // reset in CALC cycle 5
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = mk(0, 0, OP);
    pcpi_rs1 = 32'd3;
    pcpi_rs2 = 32'd3;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_outs", {pcpi_wait, pcpi_ready, pcpi_wr, 29'd0}, 32'd0);
    chk("rst_rd", pcpi_rd, 32'd0);
    pcpi_valid = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    run_op(mk(0, 2, OP), 32'h1234_5678, 32'h9ABC_DEF0,
           model(mk(0, 2, OP), 32'h1234_5678, 32'h9ABC_DEF0));

    // back-to-back with valid held
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = mk(0, 0, OP);
    pcpi_rs1 = 32'd100;
    pcpi_rs2 = 32'd3;
    sb.push_back(32'd300);
    for (int i = 0; i < 3; i++) begin
      rc[i] = -100;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk);
        #1;
        if (pcpi_ready) begin
          rc[i] = cyc;
          break;
        end
      end
      chk("b2b_rd", pcpi_rd, sb.pop_front());
      pcpi_rs1 = 32'(i + 2);
      pcpi_rs2 = 32'd1000;
      if (i < 2) sb.push_back(32'((i + 2) * 1000));
      else pcpi_valid = 1'b0;
    end
    chk("b2b_gap1", 32'(rc[1] - rc[0]), 32'd11);
    chk("b2b_gap2", 32'(rc[2] - rc[1]), 32'd11);
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
